// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_pkg
//  Purpose  : Shared constants for the two-requester ALU arbiter: FSM state
//             encoding, CMD field layout and the ALU opcode / operand-source
//             codes that requesters place in their CMD words.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_t;

  // CMD = {OPX[3:0], SRCA[1:0], SRCB[2:0]}
  localparam int C_CMD_W       = 9;
  localparam int C_CMD_OPX_LSB = 5;
  localparam int C_CMD_OPX_W   = 4;
  localparam int C_CMD_SA_LSB  = 3;
  localparam int C_CMD_SA_W    = 2;
  localparam int C_CMD_SB_LSB  = 0;
  localparam int C_CMD_SB_W    = 3;

  localparam logic [3:0] C_OPX_ADD   = 4'h0;
  localparam logic [3:0] C_OPX_SUB   = 4'h1;
  localparam logic [3:0] C_OPX_AND   = 4'h2;
  localparam logic [3:0] C_OPX_OR    = 4'h3;
  localparam logic [3:0] C_OPX_XOR   = 4'h4;
  localparam logic [3:0] C_OPX_PASSA = 4'h5;

  localparam logic [1:0] C_SRCA_REG_A = 2'd0;
  localparam logic [1:0] C_SRCA_ZERO  = 2'd1;
  localparam logic [1:0] C_SRCA_ONES  = 2'd2;
  localparam logic [1:0] C_SRCA_ONE   = 2'd3;

  localparam logic [2:0] C_SRCB_REG_B = 3'd0;
  localparam logic [2:0] C_SRCB_ZERO  = 3'd1;
  localparam logic [2:0] C_SRCB_ONE   = 3'd2;
  localparam logic [2:0] C_SRCB_TWO   = 3'd3;
  localparam logic [2:0] C_SRCB_ONES  = 3'd4;

  function automatic logic [C_CMD_OPX_W-1:0] cmd_opx(input logic [C_CMD_W-1:0] cmd);
    return cmd[C_CMD_OPX_LSB +: C_CMD_OPX_W];
  endfunction

  function automatic logic [C_CMD_SA_W-1:0] cmd_srca(input logic [C_CMD_W-1:0] cmd);
    return cmd[C_CMD_SA_LSB +: C_CMD_SA_W];
  endfunction

  function automatic logic [C_CMD_SB_W-1:0] cmd_srcb(input logic [C_CMD_W-1:0] cmd);
    return cmd[C_CMD_SB_LSB +: C_CMD_SB_W];
  endfunction

  function automatic logic [C_CMD_W-1:0] mk_cmd(input logic [3:0] opx,
                                                 input logic [1:0] srca,
                                                 input logic [2:0] srcb);
    return {opx, srca, srcb};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arb_pick
//  Purpose  : Combinational tie-break between the two ALU requesters.
//             Optional macro ALU_ARB_RR_EN selects round-robin ties (the
//             requester that is not the current owner wins); without it,
//             requester 0 has fixed priority.
//  Ports    : req0, req1 - raw request levels
//             mask_en    - when high, the current owner's request is ignored
//             owner      - index of the current/last granted requester
//             winner     - index of the chosen requester (valid only if valid)
//             valid      - at least one unmasked request present
//  Revision : 1.0  initial release
// ============================================================================
module alu_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic mask_en,
  input  logic owner,
  output logic winner,
  output logic valid
);

  logic w_req0;
  logic w_req1;

  // In CAPTURE the owner may still hold REQ on the edge ending its ACK cycle;
  // masking stops that stale level from being granted a second time.
  assign w_req0 = req0 & ~(mask_en & ~owner);
  assign w_req1 = req1 & ~(mask_en &  owner);
  assign valid  = w_req0 | w_req1;

`ifdef ALU_ARB_RR_EN
  assign winner = (w_req0 & w_req1) ? ~owner : w_req1;
`else
  assign winner = ~w_req0 & w_req1;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one combinational ALU between the execute unit (R0) and
//             the address/stack increment unit (R1). IDLE -> ISSUE -> CAPTURE
//             FSM, all outputs registered; an op takes two cycles and a new
//             grant can be taken directly from CAPTURE.
//             Optional macro ALU_ARB_RR_EN: round-robin tie-break (see
//             alu_arb_pick); default build uses fixed R0 priority.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             r0_req/r0_cmd/r0_ccl  - requester 0 request, command, CC latch
//             r0_ack                - one-cycle pulse, res valid for R0
//             r1_req/r1_cmd/r1_ack  - requester 1 request, command, ack
//             alu_r                 - ALU combinational result
//             alu_opx/alua_srcx/alub_srcx - ALU controls
//             ccl_ld                - condition-code latch enable
//             res                   - registered result
//             busy                  - state is not IDLE
//             owner                 - current/last granted requester
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_req,
  input  logic [8:0]       r0_cmd,
  input  logic             r0_ccl,
  output logic             r0_ack,
  input  logic             r1_req,
  input  logic [8:0]       r1_cmd,
  output logic             r1_ack,
  input  logic [RES_W-1:0] alu_r,
  output logic [3:0]       alu_opx,
  output logic [1:0]       alua_srcx,
  output logic [2:0]       alub_srcx,
  output logic             ccl_ld,
  output logic [RES_W-1:0] res,
  output logic             busy,
  output logic             owner
);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic                 w_mask_en;
  logic                 w_winner;
  logic                 w_valid;
  logic                 w_grant;
  logic [C_CMD_W-1:0]   w_cmd;

  logic                 r_r0_ack;
  logic                 r_r1_ack;
  logic                 r_ccl_ld;
  logic                 r_busy;
  logic                 r_owner;
  logic [3:0]           r_opx;
  logic [1:0]           r_srca;
  logic [2:0]           r_srcb;
  logic [RES_W-1:0]     r_res;

  assign w_mask_en = (r_state == ST_CAPTURE);

  alu_arb_pick u_pick (
    .req0    (r0_req),
    .req1    (r1_req),
    .mask_en (w_mask_en),
    .owner   (r_owner),
    .winner  (w_winner),
    .valid   (w_valid)
  );

  assign w_cmd = w_winner ? r1_cmd : r0_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (w_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Every output is a flop; values are computed from the transition being
  // taken so that they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r0_ack <= 1'b0;
      r_r1_ack <= 1'b0;
      r_ccl_ld <= 1'b0;
      r_busy   <= 1'b0;
      r_owner  <= 1'b1;
      r_opx    <= '0;
      r_srca   <= '0;
      r_srcb   <= '0;
      r_res    <= '0;
    end else begin
      r_busy   <= (w_state_nxt != ST_IDLE);
      // ACK and RES both become valid on entry to CAPTURE.
      r_r0_ack <= (r_state == ST_ISSUE) & ~r_owner;
      r_r1_ack <= (r_state == ST_ISSUE) &  r_owner;
      // High only for the ISSUE cycle that follows an R0 grant with CCL set.
      r_ccl_ld <= w_grant & ~w_winner & r0_ccl;
      if (r_state == ST_ISSUE) begin
        r_res <= alu_r;
      end
      if (w_grant) begin
        r_owner <= w_winner;
        r_opx   <= cmd_opx(w_cmd);
        r_srca  <= cmd_srca(w_cmd);
        r_srcb  <= cmd_srcb(w_cmd);
      end
    end
  end

  assign r0_ack    = r_r0_ack;
  assign r1_ack    = r_r1_ack;
  assign ccl_ld    = r_ccl_ld;
  assign busy      = r_busy;
  assign owner     = r_owner;
  assign alu_opx   = r_opx;
  assign alua_srcx = r_srca;
  assign alub_srcx = r_srcb;
  assign res       = r_res;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. A small stand-in ALU is
//             driven from the arbiter's control outputs; expected results are
//             computed from the command words the bench issued. Honours
//             ALU_ARB_RR_EN for the tie-break expectation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        r0_req, r0_ccl, r0_ack;
  logic [8:0]  r0_cmd;
  logic        r1_req, r1_ack;
  logic [8:0]  r1_cmd;
  logic [15:0] alu_r;
  logic [3:0]  alu_opx;
  logic [1:0]  alua_srcx;
  logic [2:0]  alub_srcx;
  logic        ccl_ld, busy, owner;
  logic [15:0] res;
  logic [15:0] a_din, b_din;
  logic        prev_ccl;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.RES_W(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_req    (r0_req),
    .r0_cmd    (r0_cmd),
    .r0_ccl    (r0_ccl),
    .r0_ack    (r0_ack),
    .r1_req    (r1_req),
    .r1_cmd    (r1_cmd),
    .r1_ack    (r1_ack),
    .alu_r     (alu_r),
    .alu_opx   (alu_opx),
    .alua_srcx (alua_srcx),
    .alub_srcx (alub_srcx),
    .ccl_ld    (ccl_ld),
    .res       (res),
    .busy      (busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [3:0] opx, input logic [1:0] sa,
                                         input logic [2:0] sb, input logic [15:0] ad,
                                         input logic [15:0] bd);
    logic [15:0] a;
    logic [15:0] b;
    case (sa)
      C_SRCA_REG_A: a = ad;
      C_SRCA_ZERO:  a = 16'h0000;
      C_SRCA_ONES:  a = 16'hFFFF;
      default:      a = 16'h0001;
    endcase
    case (sb)
      C_SRCB_REG_B: b = bd;
      C_SRCB_ZERO:  b = 16'h0000;
      C_SRCB_ONE:   b = 16'h0001;
      C_SRCB_TWO:   b = 16'h0002;
      C_SRCB_ONES:  b = 16'hFFFF;
      default:      b = 16'h00FF;
    endcase
    case (opx)
      C_OPX_ADD:   return a + b;
      C_OPX_SUB:   return a - b;
      C_OPX_AND:   return a & b;
      C_OPX_OR:    return a | b;
      C_OPX_XOR:   return a ^ b;
      C_OPX_PASSA: return a;
      default:     return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] cmd_result(input logic [8:0] cmd, input logic [15:0] ad,
                                             input logic [15:0] bd);
    return alu_fn(cmd[8:5], cmd[4:3], cmd[2:0], ad, bd);
  endfunction

  assign alu_r = alu_fn(alu_opx, alua_srcx, alub_srcx, a_din, b_din);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Continuous protocol checks: one-hot ACK and no CC latch for R1-owned ops.
  always @(negedge clk) begin
    prev_ccl <= ccl_ld;
    if (rst_n) begin
      chk("ack_onehot", {31'd0, r0_ack & r1_ack}, 32'd0);
      chk("ccl_r1_owned", {31'd0, ccl_ld & owner}, 32'd0);
    end
  end

  // One isolated op: request raised at a negedge, sampled on edge N,
  // ISSUE in the next cycle, ACK/RES in the one after.
  task automatic single_op(input string tag, input bit who, input logic [8:0] cmd,
                           input bit ccl, input logic [15:0] exp_res);
    @(negedge clk);
    if (who) begin r1_cmd = cmd; r1_req = 1'b1; end
    else     begin r0_cmd = cmd; r0_req = 1'b1; end
    r0_ccl = ccl;
    @(negedge clk);
    chk({tag, "_issue_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_issue_ccl"}, {31'd0, ccl_ld}, {31'd0, (!who && ccl)});
    chk({tag, "_issue_ack"}, {31'd0, r0_ack | r1_ack}, 32'd0);
    r0_req = 1'b0; r1_req = 1'b0; r0_ccl = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_own"}, {31'd0, who ? r1_ack : r0_ack}, 32'd1);
    chk({tag, "_ack_other"}, {31'd0, who ? r0_ack : r1_ack}, 32'd0);
    chk({tag, "_res"}, {16'd0, res}, {16'd0, exp_res});
    chk({tag, "_cap_ccl"}, {31'd0, ccl_ld}, 32'd0);
    chk({tag, "_owner"}, {31'd0, owner}, {31'd0, who});
    @(negedge clk);
    chk({tag, "_post_ack"}, {31'd0, r0_ack | r1_ack}, 32'd0);
    chk({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_res_hold"}, {16'd0, res}, {16'd0, exp_res});
  endtask

  // Compliant random requester: raises REQ with a random command, waits for
  // its ACK, checks result/latency/CC latch, drops REQ in the ACK cycle.
  task automatic requester(input int idx, input int n);
    int          gap;
    int          lat;
    bit          seen;
    bit          ccl;
    logic [8:0]  cmd;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      @(negedge clk);
      repeat (gap) @(negedge clk);
      cmd = mk_cmd(4'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      ccl = 1'($urandom_range(0, 1));
      if (idx == 0) begin r0_cmd = cmd; r0_ccl = ccl; r0_req = 1'b1; end
      else          begin r1_cmd = cmd; r1_req = 1'b1; end
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < 20) begin
        @(negedge clk);
        lat++;
        if ((idx == 0) ? r0_ack : r1_ack) seen = 1'b1;
      end
      if (!seen) begin
        chk($sformatf("rnd_timeout_r%0d", idx), 32'd0, 32'd1);
      end else begin
        chk($sformatf("rnd_res_r%0d", idx), {16'd0, res}, {16'd0, cmd_result(cmd, a_din, b_din)});
        chk($sformatf("rnd_lat_r%0d", idx), {31'd0, (lat >= 2 && lat <= 4)}, 32'd1);
        chk($sformatf("rnd_ccl_r%0d", idx), {31'd0, prev_ccl}, {31'd0, (idx == 0) && ccl});
      end
      if (idx == 0) begin r0_req = 1'b0; r0_ccl = 1'b0; end
      else          r1_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  logic [8:0]  cmd_add;
  logic [8:0]  cmd_xor;
  bit          exp_tie_r1;

  initial begin
    rst_n  = 1'b0;
    r0_req = 1'b0; r0_cmd = '0; r0_ccl = 1'b0;
    r1_req = 1'b0; r1_cmd = '0;
    a_din  = 16'h1234;
    b_din  = 16'h4321;
    cmd_add = mk_cmd(C_OPX_ADD, C_SRCA_REG_A, C_SRCB_REG_B);
    cmd_xor = mk_cmd(C_OPX_XOR, C_SRCA_REG_A, C_SRCB_REG_B);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_res", {16'd0, res}, 32'd0);
    chk("rst_opx", {28'd0, alu_opx}, 32'd0);
    chk("rst_srca", {30'd0, alua_srcx}, 32'd0);
    chk("rst_srcb", {29'd0, alub_srcx}, 32'd0);
    chk("rst_ccl", {31'd0, ccl_ld}, 32'd0);
    chk("rst_acks", {30'd0, r0_ack, r1_ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // R0 alone with CC latch requested: 1234h + 4321h
    single_op("r0_add", 1'b0, cmd_add, 1'b1, 16'h5555);

    // R1 alone, FFFFh + FFFFh, R0_CCL high but must be ignored
    a_din = 16'hFFFF;
    b_din = 16'hFFFF;
    single_op("r1_add", 1'b1, cmd_add, 1'b1, 16'hFFFE);
    a_din = 16'h1234;
    b_din = 16'h4321;

    // Both held from the same edge: R0, R1, R0 with an ACK every two cycles
    @(negedge clk);
    r0_cmd = cmd_add; r0_ccl = 1'b1; r0_req = 1'b1;
    r1_cmd = cmd_xor; r1_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("both_ack0_c%0d", i), {31'd0, r0_ack}, {31'd0, (i == 2 || i == 6)});
      chk($sformatf("both_ack1_c%0d", i), {31'd0, r1_ack}, {31'd0, (i == 4)});
      if (i == 2 || i == 6) chk($sformatf("both_res_c%0d", i), {16'd0, res}, 32'h5555);
      if (i == 4) chk("both_res_c4", {16'd0, res}, {16'd0, cmd_result(cmd_xor, a_din, b_din)});
    end
    r0_req = 1'b0; r1_req = 1'b0; r0_ccl = 1'b0;

    // Tie from IDLE with owner=0: round-robin favours R1, fixed favours R0
`ifdef ALU_ARB_RR_EN
    exp_tie_r1 = 1'b1;
`else
    exp_tie_r1 = 1'b0;
`endif
    @(negedge clk);
    chk("tie_idle_busy", {31'd0, busy}, 32'd0);
    r0_req = 1'b1; r1_req = 1'b1;
    @(negedge clk);
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);
    chk("tie_ack1", {31'd0, r1_ack}, {31'd0, exp_tie_r1});
    chk("tie_ack0", {31'd0, r0_ack}, {31'd0, !exp_tie_r1});
    chk("tie_owner", {31'd0, owner}, {31'd0, exp_tie_r1});
    repeat (2) @(negedge clk);

    // Reset pulsed during ISSUE aborts the op
    r0_cmd = cmd_add; r0_req = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n  = 1'b0;
    r0_req = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_res", {16'd0, res}, 32'd0);
    chk("abort_owner", {31'd0, owner}, 32'd1);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_no_ack_c%0d", i), {30'd0, r0_ack, r1_ack}, 32'd0);
    end
    single_op("after_abort", 1'b0, cmd_add, 1'b0, 16'h5555);

    // R0 holds REQ past its ACK: regrant only after passing through IDLE
    @(negedge clk);
    r0_cmd = cmd_add; r0_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_ack0_c%0d", i), {31'd0, r0_ack}, {31'd0, (i == 2 || i == 5)});
      chk($sformatf("hold_busy_c%0d", i), {31'd0, busy}, {31'd0, (i != 3)});
    end
    r0_req = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized concurrent traffic
    a_din = 16'($urandom);
    b_din = 16'($urandom);
    fork
      requester(0, 60);
      requester(1, 60);
    join
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
